// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: picks the next PC from sequential, branch, jump,
// jump-register, exception and eret sources, with stall, halt/resume and EPC.
module pc_sequencer #(
  parameter int                N_BIT        = 32,
  parameter int                INSTR_BYTES  = 4,
  parameter logic [N_BIT-1:0]  RESET_VECTOR = '0,
  parameter logic [N_BIT-1:0]  EXC_VECTOR   = N_BIT'(32'h0000_0180)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [N_BIT-1:0] branch_target,
  input  logic             jump,
  input  logic [N_BIT-1:0] jump_target,
  input  logic             jump_reg,
  input  logic [N_BIT-1:0] jr_target,
  input  logic             exc_req,
  input  logic             eret,
  input  logic             halt_req,
  input  logic             resume,
  output logic [N_BIT-1:0] pc,
  output logic [N_BIT-1:0] pc_plus,
  output logic             pc_valid,
  output logic [N_BIT-1:0] epc,
  output logic             misaligned_exc,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2, SPARE = 2'd3} state_t;

  typedef struct packed {
    logic             vld;
    logic [N_BIT-1:0] tgt;
  } redir_t;

  // Mask form keeps INSTR_BYTES=1 legal (no zero-width slice).
  localparam logic [N_BIT-1:0] ALIGN_MASK = N_BIT'(INSTR_BYTES - 1);
  localparam logic [N_BIT-1:0] STEP       = N_BIT'(INSTR_BYTES);

  state_t           st_q, st_d;
  logic [N_BIT-1:0] pc_d, epc_d;
  logic             mis_d;
  redir_t           redir;
  logic             redir_bad;

  assign pc_plus = pc + STEP;
  assign state   = st_q;

  always_comb begin
    redir = '0;
    if (jump_reg)          redir = '{vld: 1'b1, tgt: jr_target};
    else if (jump)         redir = '{vld: 1'b1, tgt: jump_target};
    else if (branch_taken) redir = '{vld: 1'b1, tgt: branch_target};
  end

  assign redir_bad = redir.vld && (|(redir.tgt & ALIGN_MASK));

  always_comb begin
    st_d     = st_q;
    pc_d     = pc;
    epc_d    = epc;
    mis_d    = 1'b0;
    pc_valid = 1'b0;
    case (st_q)
      BOOT: begin
        st_d = RUN;
        pc_d = RESET_VECTOR;
      end
      RUN: begin
        pc_valid = ~stall;
        if (exc_req) begin
          pc_d  = EXC_VECTOR;
          epc_d = pc;
        end else if (eret) begin
          pc_d = epc;
        end else if (halt_req) begin
          st_d = HALT;
        end else if (stall) begin
          pc_d = pc;
        end else if (redir_bad) begin
          // Misaligned redirect is dropped and converted into an exception.
          pc_d  = EXC_VECTOR;
          epc_d = pc;
          mis_d = 1'b1;
        end else if (redir.vld) begin
          pc_d = redir.tgt;
        end else begin
          pc_d = pc_plus;
        end
      end
      HALT: begin
        if (exc_req) begin
          st_d  = RUN;
          pc_d  = EXC_VECTOR;
          epc_d = pc;
        end else if (resume) begin
          st_d = RUN;
        end
      end
      default: st_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q           <= BOOT;
      pc             <= RESET_VECTOR;
      epc            <= '0;
      misaligned_exc <= 1'b0;
    end else begin
      st_q           <= st_d;
      pc             <= pc_d;
      epc            <= epc_d;
      misaligned_exc <= mis_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: 32-bit default build plus an 8-bit wrap build.
module tb_pc_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // 32-bit DUT
  logic        reset, stall, branch_taken, jump, jump_reg, exc_req, eret, halt_req, resume;
  logic [31:0] branch_target, jump_target, jr_target;
  logic [31:0] pc, pc_plus, epc;
  logic        pc_valid, misaligned_exc;
  logic [1:0]  state;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .jump_reg(jump_reg), .jr_target(jr_target),
    .exc_req(exc_req), .eret(eret), .halt_req(halt_req), .resume(resume),
    .pc(pc), .pc_plus(pc_plus), .pc_valid(pc_valid), .epc(epc),
    .misaligned_exc(misaligned_exc), .state(state)
  );

  // 8-bit DUT, RESET_VECTOR=F0 so sequential fetch reaches the wrap quickly
  logic       reset8;
  logic       z1;
  logic [7:0] z8;
  logic [7:0] pc8, pc_plus8, epc8;
  logic       pc_valid8, mis8;
  logic [1:0] state8;

  pc_sequencer #(.N_BIT(8), .INSTR_BYTES(4), .RESET_VECTOR(8'hF0), .EXC_VECTOR(8'h80)) dut8 (
    .clk(clk), .reset(reset8), .stall(z1),
    .branch_taken(z1), .branch_target(z8),
    .jump(z1), .jump_target(z8),
    .jump_reg(z1), .jr_target(z8),
    .exc_req(z1), .eret(z1), .halt_req(z1), .resume(z1),
    .pc(pc8), .pc_plus(pc_plus8), .pc_valid(pc_valid8), .epc(epc8),
    .misaligned_exc(mis8), .state(state8)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    stall = 0; branch_taken = 0; jump = 0; jump_reg = 0;
    exc_req = 0; eret = 0; halt_req = 0; resume = 0;
    branch_target = '0; jump_target = '0; jr_target = '0;
  endtask

  initial begin
    clr();
    reset = 1; reset8 = 1; z1 = 0; z8 = '0;
    step(); step();
    chk("rst_pc", pc, 32'h0);
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_valid", {31'd0, pc_valid}, 32'd0);
    chk("rst_epc", epc, 32'h0);
    chk("rst_mis", {31'd0, misaligned_exc}, 32'd0);

    reset = 0;
    step();
    chk("run_state", {30'd0, state}, 32'd1);
    chk("run_pc0", pc, 32'h0);
    chk("run_valid", {31'd0, pc_valid}, 32'd1);
    step(); chk("seq_4", pc, 32'h4);
    step(); chk("seq_8", pc, 32'h8);
    step(); chk("seq_c", pc, 32'hC);
    chk("pc_plus", pc_plus, 32'h10);
    step(); chk("seq_10", pc, 32'h10);

    // jump beats branch
    jump = 1; jump_target = 32'h40; branch_taken = 1; branch_target = 32'h80;
    step(); clr();
    chk("jmp_over_br", pc, 32'h40);

    jump = 1; jump_target = 32'h20;
    step(); clr();
    chk("jmp_20", pc, 32'h20);

    // misaligned jr
    jump_reg = 1; jr_target = 32'h102;
    step(); clr();
    chk("jr_mis_pc", pc, 32'h180);
    chk("jr_mis_epc", epc, 32'h20);
    chk("jr_mis_flag", {31'd0, misaligned_exc}, 32'd1);
    step();
    chk("mis_pulse_end", {31'd0, misaligned_exc}, 32'd0);
    chk("exc_seq", pc, 32'h184);

    jump = 1; jump_target = 32'h30;
    step(); clr();
    chk("jmp_30", pc, 32'h30);

    // exception overrides stall
    stall = 1; exc_req = 1;
    #1 chk("stall_valid", {31'd0, pc_valid}, 32'd0);
    step(); clr();
    chk("exc_stall_pc", pc, 32'h180);
    chk("exc_stall_epc", epc, 32'h30);
    step(); chk("exc_seq2", pc, 32'h184);
    eret = 1;
    step(); clr();
    chk("eret_pc", pc, 32'h30);

    stall = 1; jump = 1; jump_target = 32'h400;
    step(); clr();
    chk("stall_hold", pc, 32'h30);

    // jr beats jump
    jump_reg = 1; jr_target = 32'h50; jump = 1; jump_target = 32'h90;
    step(); clr();
    chk("jr_over_jmp", pc, 32'h50);

    halt_req = 1;
    step(); clr();
    chk("halt_state", {30'd0, state}, 32'd2);
    jump = 1; jump_target = 32'h500; eret = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("halt_pc", pc, 32'h50);
      chk("halt_valid", {31'd0, pc_valid}, 32'd0);
    end
    clr();
    resume = 1;
    step(); clr();
    chk("resume_state", {30'd0, state}, 32'd1);
    chk("resume_pc", pc, 32'h50);
    step(); chk("resume_seq", pc, 32'h54);

    halt_req = 1;
    step(); clr();
    chk("halt2_pc", pc, 32'h54);
    exc_req = 1;
    step(); clr();
    chk("halt_exc_state", {30'd0, state}, 32'd1);
    chk("halt_exc_pc", pc, 32'h180);
    chk("halt_exc_epc", epc, 32'h54);

    step(); chk("seq_184", pc, 32'h184);
    branch_taken = 1; branch_target = 32'h201;
    step(); clr();
    chk("br_mis_pc", pc, 32'h180);
    chk("br_mis_epc", epc, 32'h184);
    chk("br_mis_flag", {31'd0, misaligned_exc}, 32'd1);
    branch_taken = 1; branch_target = 32'h200;
    step(); clr();
    chk("br_ok_pc", pc, 32'h200);
    chk("br_ok_flag", {31'd0, misaligned_exc}, 32'd0);

    // reset mid-branch
    branch_taken = 1; branch_target = 32'h300; reset = 1;
    step(); clr();
    chk("midrst_pc", pc, 32'h0);
    chk("midrst_state", {30'd0, state}, 32'd0);
    chk("midrst_epc", epc, 32'h0);
    reset = 0;

    // 8-bit wrap
    reset8 = 1;
    step();
    chk("w8_rst_pc", {24'd0, pc8}, 32'hF0);
    reset8 = 0;
    step(); chk("w8_f0", {24'd0, pc8}, 32'hF0);
    step(); chk("w8_f4", {24'd0, pc8}, 32'hF4);
    step(); chk("w8_f8", {24'd0, pc8}, 32'hF8);
    step(); chk("w8_fc", {24'd0, pc8}, 32'hFC);
    chk("w8_plus", {24'd0, pc_plus8}, 32'h00);
    step(); chk("w8_wrap", {24'd0, pc8}, 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
